// File: rtl/mam_wb_pkg.sv
// Purpose : shared types and constants for the MAM-to-Wishbone bridge.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, Wishbone CTI cycle-type codes, BTE burst-type code.
package mam_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/mam_wb_if_if.sv
// Purpose : signal bundle between the MAM request/data side and the Wishbone side.
// Latency : n/a (wires only).
// Backpressure: n/a.
// Modports: master = the bridge (Wishbone master, MAM responder);
//           slave  = the environment (MAM requester plus Wishbone slave).
interface mam_wb_if_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32
);
   // MAM request channel
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_rw;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic                    req_burst;
   logic [13:0]             req_beats;
   // MAM write data channel
   logic                    write_valid;
   logic                    write_ready;
   logic [DATA_WIDTH-1:0]   write_data;
   logic [DATA_WIDTH/8-1:0] write_strb;
   // MAM read data channel
   logic                    read_valid;
   logic                    read_ready;
   logic [DATA_WIDTH-1:0]   read_data;
   // Wishbone
   logic                    CYC_O;
   logic                    STB_O;
   logic                    WE_O;
   logic                    ACK_I;
   logic [ADDR_WIDTH-1:0]   ADDR_O;
   logic [DATA_WIDTH-1:0]   DAT_O;
   logic [DATA_WIDTH-1:0]   DAT_I;
   logic [2:0]              CTI_O;
   logic [1:0]              BTE_O;

   modport master (
      input  req_valid, req_rw, req_addr, req_burst, req_beats,
      output req_ready,
      input  write_valid, write_data, write_strb,
      output write_ready,
      input  read_ready,
      output read_valid, read_data,
      output CYC_O, STB_O, WE_O, ADDR_O, DAT_O, CTI_O, BTE_O,
      input  ACK_I, DAT_I
   );

   modport slave (
      output req_valid, req_rw, req_addr, req_burst, req_beats,
      input  req_ready,
      output write_valid, write_data, write_strb,
      input  write_ready,
      output read_ready,
      input  read_valid, read_data,
      input  CYC_O, STB_O, WE_O, ADDR_O, DAT_O, CTI_O, BTE_O,
      output ACK_I, DAT_I
   );

endinterface

// File: rtl/mam_wb_if.sv
// Purpose : bridges MAM single/burst requests onto a Wishbone B3 master bus.
// Latency : data path is combinational; one request accepted per transfer, in IDLE only.
// Backpressure: write_valid/read_ready low holds STB_O low with CYC_O kept high.
// Ports   : CLK_I, RST_I (async active-low), bus (mam_wb_if_if.master).
// Option  : define MAM_WB_IF_ASSERT_EN to include simulation assertions.
module mam_wb_if
   import mam_wb_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic         CLK_I,
   input  logic         RST_I,
   mam_wb_if_if.master  bus
);

   localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [13:0]             beats_q, beats_d;
   logic                    burst_q, burst_d;
   logic                    beat_done;
   logic                    req_is_burst;
   logic                    strb_unused;

   // Strobes are carried on the MAM side but have no Wishbone counterpart here.
   assign strb_unused = ^bus.write_strb;

   // A burst request with zero beats degrades to a classic single beat.
   assign req_is_burst = bus.req_burst && (bus.req_beats != 14'd0);

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         beats_q <= '0;
         burst_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beats_q <= beats_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      beats_d         = beats_q;
      burst_d         = burst_q;
      beat_done       = 1'b0;
      bus.req_ready   = 1'b0;
      bus.CYC_O       = 1'b0;
      bus.STB_O       = 1'b0;
      bus.WE_O        = 1'b0;
      bus.DAT_O       = '0;
      bus.write_ready = 1'b0;
      bus.read_valid  = 1'b0;
      bus.read_data   = '0;

      case (state_q)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               burst_d = req_is_burst;
               beats_d = req_is_burst ? bus.req_beats : 14'd1;
               state_d = bus.req_rw ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            bus.CYC_O       = 1'b1;
            bus.WE_O        = 1'b1;
            bus.STB_O       = bus.write_valid;
            bus.DAT_O       = bus.write_data;
            // ACK is only meaningful while STB is up, so gate it here.
            beat_done       = bus.write_valid && bus.ACK_I;
            bus.write_ready = beat_done;
         end
         ST_READ: begin
            bus.CYC_O      = 1'b1;
            bus.STB_O      = bus.read_ready;
            bus.read_data  = bus.DAT_I;
            beat_done      = bus.read_ready && bus.ACK_I;
            bus.read_valid = beat_done;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (beat_done) begin
         addr_d  = addr_q + BEAT_BYTES;
         beats_d = beats_q - 14'd1;
         if (beats_q == 14'd1) begin
            state_d = ST_IDLE;
         end
      end
   end

   assign bus.ADDR_O = addr_q;
   assign bus.BTE_O  = BTE_LINEAR;
   assign bus.CTI_O  = (state_q == ST_IDLE) ? CTI_CLASSIC :
                       !burst_q             ? CTI_CLASSIC :
                       (beats_q == 14'd1)   ? CTI_END     : CTI_INCR;

`ifdef MAM_WB_IF_ASSERT_EN
   a_req_only_idle: assert property (@(posedge CLK_I) disable iff (!RST_I)
      (bus.req_valid && bus.req_ready) |-> (state_q == ST_IDLE));
   a_ack_in_cycle: assert property (@(posedge CLK_I) disable iff (!RST_I)
      bus.ACK_I |-> bus.CYC_O);
   a_no_underflow: assert property (@(posedge CLK_I) disable iff (!RST_I)
      beat_done |-> (beats_q != 14'd0));
`endif

endmodule

// File: tb/tb_mam_wb_if.sv
// Purpose : randomized and directed checking of mam_wb_if against a transfer-level model.
// Latency : n/a (testbench).
// Backpressure: bench randomly drops write_valid/read_ready and ACK_I.
module tb_mam_wb_if;

   localparam int DW = 16;
   localparam int AW = 32;

   logic CLK_I;
   logic RST_I;
   int   n_chk;
   int   n_pass;

   mam_wb_if_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mam_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .bus   (bus)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic idle_inputs();
      bus.req_valid   = 1'b0;
      bus.write_valid = 1'b0;
      bus.read_ready  = 1'b0;
      bus.ACK_I       = 1'b0;
   endtask

   // One MAM transfer. Expected Wishbone beats are derived from the request:
   // beat k sits at base + 2k (mod 2^32), carries dat[k], and its cycle type is
   // classic for a single beat, incrementing for burst beats, end for the last.
   task automatic run_txn(input bit rw, input logic [31:0] base, input bit burst,
                          input int beats, input logic [15:0] d0, input bit rnd,
                          input int stall_beat, input int stall_len, input int rst_beat);
      int            n;
      bit            isb;
      logic [15:0]   dat[$];
      int            k;
      int            cyc;
      int            stalls;
      bit            v;
      bit            a;
      logic [31:0]   exp_addr;
      logic [2:0]    exp_cti;
      isb = burst && (beats != 0);
      n   = isb ? beats : 1;
      for (int i = 0; i < n; i++) dat.push_back(rnd ? 16'($urandom) : d0 + 16'(i));

      @(negedge CLK_I);
      bus.req_valid = 1'b1;
      bus.req_rw    = rw;
      bus.req_addr  = base;
      bus.req_burst = burst;
      bus.req_beats = 14'(beats);
      #1 chk("req_ready_idle", bus.req_ready, 1);
      @(negedge CLK_I);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_beats = 14'($urandom);

      k = 0; cyc = 0; stalls = 0;
      while (k < n && cyc < 2000) begin
         v = 1'b1;
         a = 1'b1;
         if (rnd) begin
            v = ($urandom % 4) != 0;
            a = ($urandom % 3) != 0;
         end
         if (k == stall_beat && stalls < stall_len) begin
            v = 1'b0;
            stalls++;
         end
         if (k == rst_beat) begin
            idle_inputs();
            RST_I = 1'b0;
            #1;
            chk("rst_cyc", bus.CYC_O, 0);
            chk("rst_stb", bus.STB_O, 0);
            chk("rst_addr", bus.ADDR_O, 0);
            chk("rst_cti", bus.CTI_O, 0);
            @(negedge CLK_I);
            RST_I = 1'b1;
            #1 chk("rst_rel_req_ready", bus.req_ready, 1);
            return;
         end
         bus.write_valid = rw && v;
         bus.read_ready  = !rw && v;
         bus.write_data  = rw ? dat[k] : 16'($urandom);
         bus.DAT_I       = rw ? 16'($urandom) : dat[k];
         bus.ACK_I       = a;
         #1;
         chk("cyc", bus.CYC_O, 1);
         chk("we", bus.WE_O, rw);
         chk("stb", bus.STB_O, v);
         chk("bte", bus.BTE_O, 0);
         chk("req_ready_busy", bus.req_ready, 0);
         if (v && a) begin
            exp_addr = base + 32'(2 * k);
            exp_cti  = !isb ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010;
            chk("addr", bus.ADDR_O, exp_addr);
            chk("cti", bus.CTI_O, exp_cti);
            if (rw) begin
               chk("dat_o", bus.DAT_O, dat[k]);
               chk("write_ready", bus.write_ready, 1);
            end else begin
               chk("read_valid", bus.read_valid, 1);
               chk("read_data", bus.read_data, dat[k]);
            end
            k++;
         end else begin
            if (rw) chk("write_ready_hold", bus.write_ready, 0);
            else    chk("read_valid_hold", bus.read_valid, 0);
         end
         cyc++;
         @(negedge CLK_I);
      end
      if (k < n) chk("beat_timeout", k, n);
      idle_inputs();
      #1;
      chk("end_cyc", bus.CYC_O, 0);
      chk("end_stb", bus.STB_O, 0);
      chk("end_req_ready", bus.req_ready, 1);
      chk("end_write_ready", bus.write_ready, 0);
      chk("end_read_valid", bus.read_valid, 0);
   endtask

   initial begin
      bit          rw;
      bit          bst;
      logic [31:0] base;
      n_chk  = 0;
      n_pass = 0;
      RST_I  = 1'b0;
      idle_inputs();
      bus.req_rw     = 1'b0;
      bus.req_addr   = '0;
      bus.req_burst  = 1'b0;
      bus.req_beats  = '0;
      bus.write_data = '0;
      bus.write_strb = '1;
      bus.DAT_I      = '0;
      repeat (3) @(negedge CLK_I);
      #1;
      chk("reset_cyc", bus.CYC_O, 0);
      chk("reset_stb", bus.STB_O, 0);
      chk("reset_we", bus.WE_O, 0);
      chk("reset_write_ready", bus.write_ready, 0);
      chk("reset_read_valid", bus.read_valid, 0);
      chk("reset_addr", bus.ADDR_O, 0);
      chk("reset_cti", bus.CTI_O, 0);
      chk("reset_bte", bus.BTE_O, 0);
      chk("reset_dat_o", bus.DAT_O, 0);
      @(negedge CLK_I);
      RST_I = 1'b1;
      #1 chk("first_req_ready", bus.req_ready, 1);

      // Burst write of six beats at address 0, data 1..6, always acked.
      run_txn(1, 32'h0, 1, 6, 16'h0001, 0, -1, 0, -1);
      // Single write of 0x000F.
      run_txn(1, 32'h100, 0, 0, 16'h000F, 0, -1, 0, -1);
      // Burst read of four beats, DAT_I 1..4.
      run_txn(0, 32'h40, 1, 4, 16'h0001, 0, -1, 0, -1);
      // Write stalled for three cycles before beat 3.
      run_txn(1, 32'h200, 1, 6, 16'h0011, 0, 2, 3, -1);
      // Burst request with zero beats falls back to one classic beat.
      run_txn(0, 32'h300, 1, 0, 16'h00AA, 0, -1, 0, -1);
      // Burst crossing the top of the address space.
      run_txn(1, 32'hFFFF_FFFC, 1, 5, 16'h0100, 0, -1, 0, -1);
      // Reset asserted on the third of six beats, then a clean transfer.
      run_txn(1, 32'h400, 1, 6, 16'h0021, 0, -1, 0, 2);
      run_txn(0, 32'h500, 1, 3, 16'h0031, 0, -1, 0, -1);

      for (int t = 0; t < 30; t++) begin
         rw   = 1'($urandom);
         bst  = 1'($urandom);
         base = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFE);
         run_txn(rw, base, bst, bst ? int'($urandom_range(2, 9)) : int'($urandom_range(0, 20)),
                 16'h0, 1, -1, 0, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mam_wb_if.md
MAM_WB_IF -- requirements
Module: mam_wb_if

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: Wishbone/MAM data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-004 CLK_I  in  1  clock; all logic on rising edge.
REQ-005 RST_I  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when both high.
REQ-008 req_rw  in  1  1=write, 0=read.
REQ-009 req_addr  in  ADDR_WIDTH  start byte address.
REQ-010 req_burst  in  1  1=burst, 0=single beat.
REQ-011 req_beats  in  14  burst beat count.
REQ-012 write_valid / write_ready  in / out  1 each  write data handshake.
REQ-013 write_data  in  DATA_WIDTH  write beat data.
REQ-014 write_strb  in  DATA_WIDTH/8  byte strobes; accepted and ignored.
REQ-015 read_valid / read_ready  out / in  1 each  read data handshake.
REQ-016 read_data  out  DATA_WIDTH  read beat data.
REQ-017 CYC_O, STB_O, WE_O  out  1 each  Wishbone cycle, strobe, write enable.
REQ-018 ACK_I  in  1  Wishbone acknowledge.
REQ-019 ADDR_O  out  ADDR_WIDTH; DAT_O  out  DATA_WIDTH; DAT_I  in  DATA_WIDTH.
REQ-020 CTI_O  out  3  cycle type; BTE_O  out  2  burst type.

Function
REQ-021 FSM states: IDLE, WRITE, READ; req_ready SHALL be 1 only in IDLE.
REQ-022 IDLE: on req_valid, latch addr, rw, beat count; go to WRITE if req_rw=1, else READ. Beat count = req_beats if req_burst=1 and req_beats!=0; otherwise 1.
REQ-023 WRITE: CYC_O=1, WE_O=1, STB_O=write_valid, DAT_O=write_data, write_ready=ACK_I (combinational).
REQ-024 READ: CYC_O=1, WE_O=0, STB_O=read_ready, read_valid=ACK_I, read_data=DAT_I (combinational).
REQ-025 A beat completes on a cycle where STB_O and ACK_I are both high. The completing beat SHALL increment ADDR_O by DATA_WIDTH/8 and decrement the remaining-beat count.
REQ-026 CTI_O SHALL be 3'b000 for a single beat, 3'b010 for non-last burst beats, and 3'b111 for the last burst beat. BTE_O SHALL be constant 2'b00 (linear).
REQ-027 After the last beat completes, the FSM SHALL return to IDLE. CYC_O and STB_O SHALL be 0 from the next cycle, and req_ready SHALL be 1.
REQ-028 Outside WRITE/READ: CYC_O=STB_O=WE_O=0, write_ready=0, read_valid=0.
REQ-029 Stalls: write_valid=0 or read_ready=0 SHALL hold STB_O low while keeping CYC_O high. No beat is lost or duplicated.
REQ-030 ACK_I SHALL be ignored while STB_O=0.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH. Maximum burst is 16383 beats.

Reset
REQ-032 While RST_I=0: state IDLE; CYC_O, STB_O, WE_O, write_ready, read_valid = 0; ADDR_O, CTI_O, BTE_O, DAT_O = 0; beat count = 0.
REQ-033 Reset asserted mid-transfer SHALL abort immediately, with CYC_O low asynchronously.
REQ-034 req_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-035 Macro MAM_WB_IF_ASSERT_EN defined: the block SHALL include simulation assertions that check the following.
- No req_valid is accepted outside IDLE.
- ACK_I arrives only while CYC_O is high.
- The beat count never underflows.
REQ-036 Macro absent: no assertion code; functional behaviour identical.

Structure
REQ-037 Package mam_wb_pkg SHALL hold:
- the FSM state enum;
- CTI constants (CLASSIC=000, INCR=010, END=111);
- the BTE_LINEAR constant.
REQ-038 The block SHALL be a single module with no sub-module.

Verification
REQ-039 Burst write: req_beats=6, addr 0, data 0x0001..0x0006, ACK_I always 1.
- DAT_O SHALL be 1..6 at ADDR_O 0,2,4,6,8,10.
- CTI_O SHALL be 010 x5, then 111.
- The FSM SHALL then be IDLE with req_ready=1.
REQ-040 Single write: req_burst=0, data 0x000F → one beat with CTI_O=000, WE_O=1, DAT_O=0x000F.
REQ-041 Burst read: req_beats=4, DAT_I 1..4 acked → read_valid pulses with read_data 1,2,3,4. CTI_O SHALL be 010,010,010,111.
REQ-042 Backpressure: write_valid low for 3 cycles mid-burst → STB_O low and CYC_O high for 3 cycles, then the burst resumes at the next address.
REQ-043 Reset asserted during beat 3 of 6 → CYC_O=0 immediately and req_ready=1 after release.
